// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipelined MIPS control unit: opcodes, functs, ALU codes, control-vector layout.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pipe_ctrl_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type funct field
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // ALU operation codes; wider ALU control buses zero-fill above bit 2
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    // Bit positions inside the packed control vector carried from D into E
    localparam int CTL_REGWRITE = 0;
    localparam int CTL_REGDST   = 1;
    localparam int CTL_ALUSRC   = 2;
    localparam int CTL_ZEROEXT  = 3;
    localparam int CTL_MEMWRITE = 4;
    localparam int CTL_MEMTOREG = 5;
    localparam int CTL_MEMEN    = 6;
    localparam int CTL_LINK     = 7;
    localparam int CTL_VALID    = 8;
    localparam int CTL_W        = 9;

    // Controls still needed once an instruction has left E
    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
        logic memen;
        logic link;
        logic valid;
    } m_ctl_t;

    // Controls still needed in writeback
    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic link;
        logic valid;
    } w_ctl_t;

endpackage

// File: rtl/pipe_ctrl_decoder.sv
// Decodes one MIPS instruction into the packed control vector, ALU code and D-stage flow flags.
// Latency: purely combinational.
// Backpressure: none; output follows inst every cycle.
module pipe_ctrl_decoder
    import pipe_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3
) (
    input  logic [31:0]          inst,
    output logic [CTL_W-1:0]     ctl,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    output logic                 jump,
    output logic                 branch,
    output logic                 bne,
    output logic                 jr,
    output logic                 illegal
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [2:0] alu_code;
    logic       r_alu;

    assign op       = inst[31:26];
    assign funct    = inst[5:0];
    assign alu_ctrl = ALUCTRL_W'(alu_code);

    // Opcode/funct decode; the all-zero word is a NOP and anything unknown is flagged illegal with no controls
    always_comb begin
        ctl      = '0;
        alu_code = ALU_AND;
        jump     = 1'b0;
        branch   = 1'b0;
        bne      = 1'b0;
        jr       = 1'b0;
        illegal  = 1'b0;
        r_alu    = 1'b0;
        case (op)
            OP_RTYPE: begin
                if (inst != 32'd0) begin
                    case (funct)
                        FN_ADD: begin r_alu = 1'b1; alu_code = ALU_ADD; end
                        FN_SUB: begin r_alu = 1'b1; alu_code = ALU_SUB; end
                        FN_AND: begin r_alu = 1'b1; alu_code = ALU_AND; end
                        FN_OR:  begin r_alu = 1'b1; alu_code = ALU_OR;  end
                        FN_NOR: begin r_alu = 1'b1; alu_code = ALU_NOR; end
                        FN_SLT: begin r_alu = 1'b1; alu_code = ALU_SLT; end
                        FN_JR: begin
                            jr             = 1'b1;
                            ctl[CTL_VALID] = 1'b1;
                        end
                        default: illegal = 1'b1;
                    endcase
                    if (r_alu) begin
                        ctl[CTL_REGWRITE] = 1'b1;
                        ctl[CTL_REGDST]   = 1'b1;
                        ctl[CTL_VALID]    = 1'b1;
                    end
                end
            end
            OP_LW: begin
                ctl[CTL_REGWRITE] = 1'b1;
                ctl[CTL_ALUSRC]   = 1'b1;
                ctl[CTL_MEMTOREG] = 1'b1;
                ctl[CTL_MEMEN]    = 1'b1;
                ctl[CTL_VALID]    = 1'b1;
                alu_code          = ALU_ADD;
            end
            OP_SW: begin
                ctl[CTL_ALUSRC]   = 1'b1;
                ctl[CTL_MEMWRITE] = 1'b1;
                ctl[CTL_MEMEN]    = 1'b1;
                ctl[CTL_VALID]    = 1'b1;
                alu_code          = ALU_ADD;
            end
            OP_BEQ, OP_BNE: begin
                branch         = 1'b1;
                bne            = (op == OP_BNE);
                ctl[CTL_VALID] = 1'b1;
                alu_code       = ALU_SUB;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                ctl[CTL_REGWRITE] = 1'b1;
                ctl[CTL_ALUSRC]   = 1'b1;
                ctl[CTL_ZEROEXT]  = (op == OP_ANDI) || (op == OP_ORI);
                ctl[CTL_VALID]    = 1'b1;
                case (op)
                    OP_ANDI: alu_code = ALU_AND;
                    OP_ORI:  alu_code = ALU_OR;
                    OP_SLTI: alu_code = ALU_SLT;
                    default: alu_code = ALU_ADD;
                endcase
            end
            OP_J: begin
                jump           = 1'b1;
                ctl[CTL_VALID] = 1'b1;
            end
            OP_JAL: begin
                jump              = 1'b1;
                ctl[CTL_REGWRITE] = 1'b1;
                ctl[CTL_LINK]     = 1'b1;
                ctl[CTL_VALID]    = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS control: decodes in D, registers controls through E, M, W and counts retirements.
// Latency: E one cycle after D, M after two, W after three (while en is high).
// Backpressure: en low freezes every stage and the counter; clr_e bubbles E only when en is high.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3,   // ALU control width, at least 3
    parameter int CNT_W     = 32   // retired-instruction counter width
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          inst_d,
    input  logic                 en,
    input  logic                 clr_e,
    output logic                 jump_d,
    output logic                 branch_d,
    output logic                 bne_d,
    output logic                 jr_d,
    output logic                 illegal_d,
    output logic [ALUCTRL_W-1:0] alu_ctrl_e,
    output logic                 alusrc_e,
    output logic                 regdst_e,
    output logic                 zeroext_e,
    output logic                 memtoreg_e,
    output logic                 regwrite_e,
    output logic                 memwrite_m,
    output logic                 memen_m,
    output logic                 memtoreg_m,
    output logic                 regwrite_m,
    output logic                 regwrite_w,
    output logic                 memtoreg_w,
    output logic                 link_w,
    output logic                 valid_e,
    output logic                 valid_m,
    output logic                 valid_w,
    output logic [CNT_W-1:0]     retired_cnt
);

    logic [CTL_W-1:0]     ctl_dec;
    logic [ALUCTRL_W-1:0] alu_dec;

    logic [CTL_W-1:0]     ctl_e_q, ctl_e_d;
    logic [ALUCTRL_W-1:0] alu_e_q, alu_e_d;
    m_ctl_t               ctl_m_q, ctl_m_d;
    w_ctl_t               ctl_w_q, ctl_w_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    pipe_ctrl_decoder #(
        .ALUCTRL_W (ALUCTRL_W)
    ) u_decoder (
        .inst      (inst_d),
        .ctl       (ctl_dec),
        .alu_ctrl  (alu_dec),
        .jump      (jump_d),
        .branch    (branch_d),
        .bne       (bne_d),
        .jr        (jr_d),
        .illegal   (illegal_d)
    );

    // D->E: freeze wins over flush, flush loads a bubble, otherwise take the decode
    always_comb begin
        ctl_e_d = ctl_e_q;
        alu_e_d = alu_e_q;
        if (en) begin
            if (clr_e) begin
                ctl_e_d = '0;
                alu_e_d = '0;
            end else begin
                ctl_e_d = ctl_dec;
                alu_e_d = alu_dec;
            end
        end
    end

    // E->M and M->W advance together on en; these stages are never flushed
    always_comb begin
        ctl_m_d = ctl_m_q;
        ctl_w_d = ctl_w_q;
        if (en) begin
            ctl_m_d.regwrite = ctl_e_q[CTL_REGWRITE];
            ctl_m_d.memtoreg = ctl_e_q[CTL_MEMTOREG];
            ctl_m_d.memwrite = ctl_e_q[CTL_MEMWRITE];
            ctl_m_d.memen    = ctl_e_q[CTL_MEMEN];
            ctl_m_d.link     = ctl_e_q[CTL_LINK];
            ctl_m_d.valid    = ctl_e_q[CTL_VALID];
            ctl_w_d.regwrite = ctl_m_q.regwrite;
            ctl_w_d.memtoreg = ctl_m_q.memtoreg;
            ctl_w_d.link     = ctl_m_q.link;
            ctl_w_d.valid    = ctl_m_q.valid;
        end
    end

    // Count each real instruction once, on the edge that moves it from M into W
    always_comb begin
        cnt_d = cnt_q;
        if (en && ctl_m_q.valid) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Stage registers and counter; reset drops everything in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctl_e_q <= '0;
            alu_e_q <= '0;
            ctl_m_q <= '0;
            ctl_w_q <= '0;
            cnt_q   <= '0;
        end else begin
            ctl_e_q <= ctl_e_d;
            alu_e_q <= alu_e_d;
            ctl_m_q <= ctl_m_d;
            ctl_w_q <= ctl_w_d;
            cnt_q   <= cnt_d;
        end
    end

    assign alu_ctrl_e  = alu_e_q;
    assign alusrc_e    = ctl_e_q[CTL_ALUSRC];
    assign regdst_e    = ctl_e_q[CTL_REGDST];
    assign zeroext_e   = ctl_e_q[CTL_ZEROEXT];
    assign memtoreg_e  = ctl_e_q[CTL_MEMTOREG];
    assign regwrite_e  = ctl_e_q[CTL_REGWRITE];
    assign valid_e     = ctl_e_q[CTL_VALID];
    assign memwrite_m  = ctl_m_q.memwrite;
    assign memen_m     = ctl_m_q.memen;
    assign memtoreg_m  = ctl_m_q.memtoreg;
    assign regwrite_m  = ctl_m_q.regwrite;
    assign valid_m     = ctl_m_q.valid;
    assign regwrite_w  = ctl_w_q.regwrite;
    assign memtoreg_w  = ctl_w_q.memtoreg;
    assign link_w      = ctl_w_q.link;
    assign valid_w     = ctl_w_q.valid;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: decode flags, stage propagation, flush, freeze, reset and counter wrap.
// Latency: checks sampled 2 time units after each rising edge.
// Backpressure: exercised through en/clr_e vectors.
module tb_pipe_ctrl_unit;

    localparam logic [31:0] I_LW    = 32'h8C080004;
    localparam logic [31:0] I_SW    = 32'hAC080004;
    localparam logic [31:0] I_ADDI  = 32'h20220005;
    localparam logic [31:0] I_ILL   = 32'hFC000000;
    localparam logic [31:0] I_ADDU  = 32'h00221821;

    logic        clk;
    logic        rst;
    logic [31:0] inst_d;
    logic        en;
    logic        clr_e;
    logic        jump_d, branch_d, bne_d, jr_d, illegal_d;
    logic [2:0]  alu_ctrl_e;
    logic        alusrc_e, regdst_e, zeroext_e, memtoreg_e, regwrite_e;
    logic        memwrite_m, memen_m, memtoreg_m, regwrite_m;
    logic        regwrite_w, memtoreg_w, link_w;
    logic        valid_e, valid_m, valid_w;
    logic [1:0]  retired_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int retired  = 0;

    // ALU stream: add sub and or nor slt addi andi slti
    logic [31:0] alu_inst [9] = '{32'h00221820, 32'h00221822, 32'h00221824, 32'h00221825,
                                  32'h00221827, 32'h0022182A, 32'h20220005, 32'h30220005,
                                  32'h28220005};
    logic [2:0]  alu_exp  [9] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b100, 3'b111,
                                  3'b010, 3'b000, 3'b111};
    logic        zext_exp [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic        rdst_exp [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};

    // Flow stream: beq bne jal jr; expected {branch, bne, jump, jr}
    logic [31:0] bj_inst  [4] = '{32'h10220003, 32'h14220003, 32'h0C000010, 32'h03E00008};
    logic [3:0]  bj_exp   [4] = '{4'b1000, 4'b1100, 4'b0010, 4'b0001};

    pipe_ctrl_unit #(
        .ALUCTRL_W (3),
        .CNT_W     (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_d      (inst_d),
        .en          (en),
        .clr_e       (clr_e),
        .jump_d      (jump_d),
        .branch_d    (branch_d),
        .bne_d       (bne_d),
        .jr_d        (jr_d),
        .illegal_d   (illegal_d),
        .alu_ctrl_e  (alu_ctrl_e),
        .alusrc_e    (alusrc_e),
        .regdst_e    (regdst_e),
        .zeroext_e   (zeroext_e),
        .memtoreg_e  (memtoreg_e),
        .regwrite_e  (regwrite_e),
        .memwrite_m  (memwrite_m),
        .memen_m     (memen_m),
        .memtoreg_m  (memtoreg_m),
        .regwrite_m  (regwrite_m),
        .regwrite_w  (regwrite_w),
        .memtoreg_w  (memtoreg_w),
        .link_w      (link_w),
        .valid_e     (valid_e),
        .valid_m     (valid_m),
        .valid_w     (valid_w),
        .retired_cnt (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        inst_d = 32'd0;
        repeat (3) tick();
    endtask

    task automatic check_cnt(input string tag);
        logic [1:0] exp_cnt;
        exp_cnt = retired[1:0];
        check(tag, 32'(retired_cnt), 32'(exp_cnt));
    endtask

    initial begin
        rst    = 1'b0;
        en     = 1'b1;
        clr_e  = 1'b0;
        inst_d = 32'd0;

        // Held in reset while lw toggles in D: nothing enters the pipe
        repeat (3) begin
            inst_d = I_LW;
            tick();
            check("rst_memtoreg_e", 32'(memtoreg_e), 32'd0);
            check("rst_valid_e", 32'(valid_e), 32'd0);
            check("rst_regwrite_w", 32'(regwrite_w), 32'd0);
            check("rst_cnt", 32'(retired_cnt), 32'd0);
            inst_d = 32'd0;
            tick();
        end

        // Release, then lw followed by NOPs walks E -> M -> W
        rst    = 1'b1;
        inst_d = I_LW;
        tick();
        check("lw_memtoreg_e", 32'(memtoreg_e), 32'd1);
        check("lw_valid_e", 32'(valid_e), 32'd1);
        check("lw_alusrc_e", 32'(alusrc_e), 32'd1);
        check("lw_memtoreg_m0", 32'(memtoreg_m), 32'd0);
        inst_d = 32'd0;
        tick();
        check("lw_memtoreg_m", 32'(memtoreg_m), 32'd1);
        check("lw_memen_m", 32'(memen_m), 32'd1);
        check("lw_memtoreg_e0", 32'(memtoreg_e), 32'd0);
        check("lw_cnt_before", 32'(retired_cnt), 32'd0);
        tick();
        check("lw_memtoreg_w", 32'(memtoreg_w), 32'd1);
        check("lw_regwrite_w", 32'(regwrite_w), 32'd1);
        check("lw_valid_w", 32'(valid_w), 32'd1);
        retired = 1;
        check_cnt("lw_cnt");
        tick();
        check("lw_memtoreg_w0", 32'(memtoreg_w), 32'd0);
        check_cnt("lw_cnt_hold");

        // ALU-code stream through E
        for (int i = 0; i < 9; i++) begin
            inst_d = alu_inst[i];
            tick();
            check($sformatf("alu_ctrl_e[%0d]", i), 32'(alu_ctrl_e), 32'(alu_exp[i]));
            check($sformatf("zeroext_e[%0d]", i), 32'(zeroext_e), 32'(zext_exp[i]));
            check($sformatf("regdst_e[%0d]", i), 32'(regdst_e), 32'(rdst_exp[i]));
            check($sformatf("regwrite_e[%0d]", i), 32'(regwrite_e), 32'd1);
        end
        drain();
        retired += 9;
        check_cnt("alu_cnt");

        // Branch / jump flags in D, then jal and jr down to W
        for (int i = 0; i < 4; i++) begin
            inst_d = bj_inst[i];
            #1;
            check($sformatf("flow_flags[%0d]", i), 32'({branch_d, bne_d, jump_d, jr_d}), 32'(bj_exp[i]));
            check($sformatf("flow_illegal[%0d]", i), 32'(illegal_d), 32'd0);
            tick();
        end
        inst_d = 32'd0;
        tick();
        check("jal_link_w", 32'(link_w), 32'd1);
        check("jal_regwrite_w", 32'(regwrite_w), 32'd1);
        check("jr_regwrite_m", 32'(regwrite_m), 32'd0);
        tick();
        check("jr_regwrite_w", 32'(regwrite_w), 32'd0);
        check("jr_link_w", 32'(link_w), 32'd0);
        check("jr_valid_w", 32'(valid_w), 32'd1);
        retired += 4;
        check_cnt("flow_cnt");

        // Flush: lw squashed into a bubble at E, never retires
        inst_d = I_LW;
        clr_e  = 1'b1;
        tick();
        check("flush_valid_e", 32'(valid_e), 32'd0);
        check("flush_regwrite_e", 32'(regwrite_e), 32'd0);
        check("flush_memtoreg_e", 32'(memtoreg_e), 32'd0);
        clr_e = 1'b0;
        drain();
        check("flush_valid_w", 32'(valid_w), 32'd0);
        check("flush_memtoreg_w", 32'(memtoreg_w), 32'd0);
        check_cnt("flush_cnt");

        // Freeze with sw in E; clr_e during freeze must not take effect
        inst_d = I_SW;
        tick();
        check("sw_valid_e", 32'(valid_e), 32'd1);
        inst_d = 32'd0;
        en     = 1'b0;
        clr_e  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("frz_valid_e[%0d]", i), 32'(valid_e), 32'd1);
            check($sformatf("frz_alusrc_e[%0d]", i), 32'(alusrc_e), 32'd1);
            check($sformatf("frz_memwrite_m[%0d]", i), 32'(memwrite_m), 32'd0);
        end
        en    = 1'b1;
        clr_e = 1'b0;
        tick();
        check("sw_memwrite_m", 32'(memwrite_m), 32'd1);
        check("sw_memen_m", 32'(memen_m), 32'd1);
        check("sw_valid_e_after", 32'(valid_e), 32'd0);
        tick();
        check("sw_valid_w", 32'(valid_w), 32'd1);
        check("sw_regwrite_w", 32'(regwrite_w), 32'd0);
        retired += 1;
        check_cnt("sw_cnt");

        // Illegal encodings and the NOP
        inst_d = I_ILL;
        #1;
        check("ill_illegal_d", 32'(illegal_d), 32'd1);
        check("ill_jump_d", 32'(jump_d), 32'd0);
        tick();
        check("ill_valid_e", 32'(valid_e), 32'd0);
        check("ill_regwrite_e", 32'(regwrite_e), 32'd0);
        inst_d = I_ADDU;
        #1;
        check("addu_illegal_d", 32'(illegal_d), 32'd1);
        inst_d = 32'd0;
        #1;
        check("nop_illegal_d", 32'(illegal_d), 32'd0);

        // Mid-operation async reset drops in-flight work, then 5 retirements wrap a 2-bit counter
        inst_d = I_ADDI;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("arst_valid_e", 32'(valid_e), 32'd0);
        check("arst_valid_m", 32'(valid_m), 32'd0);
        check("arst_cnt", 32'(retired_cnt), 32'd0);
        inst_d = 32'd0;
        tick();
        rst     = 1'b1;
        retired = 0;
        repeat (5) begin
            inst_d = I_ADDI;
            tick();
        end
        drain();
        retired += 5;
        check("wrap_cnt", 32'(retired_cnt), 32'd1);
        check_cnt("wrap_cnt_model");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Second-generation pipelined MIPS control unit.
- Decodes the instruction in D and carries control bits through E, M and W in registered stages.
- Adds an extended ISA (bne, andi/ori, slti, jal, jr, nor) with configurable ALU-control width.
- Adds global freeze, E-stage bubble insertion, per-stage valid tracking, illegal-instruction detection and a retired-instruction counter.
- Sits between the fetch/decode datapath and the hazard unit.

Parameters:
- ALUCTRL_W, 3: width of the ALU control code; must be >= 3, upper bits zero-filled.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- inst_d  in  32  instruction in decode stage.
- en  in  1  global pipeline enable; 0 freezes all control registers.
- clr_e  in  1  flush: load a bubble into the E stage.
- jump_d  out  1  j/jal in D (combinational).
- branch_d  out  1  beq/bne in D.
- bne_d  out  1  branch sense: 1 = bne.
- jr_d  out  1  jr in D.
- illegal_d  out  1  unknown opcode/funct in D.
- alu_ctrl_e  out  ALUCTRL_W  ALU operation in E.
- alusrc_e  out  1  ALU operand B is the immediate.
- regdst_e  out  1  destination register is rd.
- zeroext_e  out  1  immediate is zero-extended (andi/ori).
- memtoreg_e  out  1  load in E (for load-use detection).
- regwrite_e  out  1  register write in E.
- memwrite_m  out  1  store in M.
- memen_m  out  1  data-memory access in M.
- memtoreg_m  out  1  load in M.
- regwrite_m  out  1  register write in M.
- regwrite_w  out  1  register write in W.
- memtoreg_w  out  1  writeback from memory.
- link_w  out  1  jal writeback of PC+8 to $31.
- valid_e, valid_m, valid_w  out  1 each  stage holds a real instruction.
- retired_cnt  out  CNT_W  count of instructions passing W.

Behaviour:
- Decode (combinational from inst_d):
  - R-type (op 000000) funct: add 100000, sub 100010, and 100100, or 100101, nor 100111, slt 101010, jr 001000.
  - I/J-type op: lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, slti 001010, j 000010, jal 000011.
- ALU codes: and 000, or 001, add 010, nor 100, sub 110, slt 111. lw/sw/addi use add; beq/bne use sub; slti uses slt.
- inst_d == 0 is a NOP: all controls 0, illegal_d = 0, not valid.
- Any other unlisted encoding: illegal_d = 1, all controls 0, not valid.
- jr and j are valid but write no register. jal sets regwrite and link.
- Valid in D = decoded, not NOP, not illegal.
- D->E register:
  - en = 0: hold.
  - en = 1 and clr_e = 1: load all zeros (bubble).
  - en = 1 and clr_e = 0: load decoded controls plus valid.
  - en = 0 takes priority over clr_e; the flush is not remembered.
- E->M and M->W registers load on en = 1 and hold otherwise. There is no clear on these stages.
- Latency: controls appear at E one cycle after D, at M after two, at W after three (with en = 1 throughout).
- retired_cnt:
  - Increments by 1 on each edge where en = 1 and valid_m = 1, i.e. each instruction counted once as it enters W.
  - Wraps modulo 2^CNT_W.
  - Frozen while en = 0.
- Reset (rst = 0, asynchronous):
  - All registered outputs, valid bits and retired_cnt go to 0 immediately.
  - Mid-operation reset discards in-flight instructions and does not count them.
  - Release is synchronous to the next clk edge; the first load occurs on the first edge with rst = 1.
- D-stage outputs are purely combinational; they are unaffected by en and rst.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - opcode/funct constants
  - ALU code constants (ALUCTRL_W-sized)
  - bit-index constants for the packed control vector (regwrite, regdst, alusrc, zeroext, memwrite, memtoreg, memen, link, valid)
- One combinational sub-module, pipe_ctrl_decoder (inst -> packed controls + alu code + D-stage flags).
- The top level holds the three stage registers and the counter.

Test Plan:
- Hold rst = 0 while toggling inst_d = lw (0x8C080004) -> all E/M/W outputs 0, retired_cnt = 0. Release, apply lw then NOPs -> memtoreg_e/m/w assert on cycles 1/2/3, retired_cnt = 1 at cycle 3.
- Stream add, sub, and, or, nor, slt, addi, andi, slti -> alu_ctrl_e = 010, 110, 000, 001, 100, 111, 010, 000, 111. zeroext_e = 1 only for andi; regdst_e = 1 only for R-type.
- inst_d = beq then bne then jal then jr:
  - branch_d = 1, 1, 0, 0; bne_d = 0, 1, 0, 0; jump_d = 0, 0, 1, 0; jr_d = 0, 0, 0, 1.
  - link_w = 1 three cycles after jal; regwrite_w = 0 for jr.
- lw in D with clr_e = 1 -> valid_e = 0, regwrite_e = 0, and the lw never reaches W; retired_cnt unchanged.
- en = 0 for 3 cycles with sw in E, plus clr_e = 1 during the freeze -> outputs hold and sw survives. Re-enable -> memwrite_m = 1 next cycle.
- inst_d = 0xFC000000 -> illegal_d = 1, valid_e = 0. With CNT_W = 2, retire 5 instructions -> retired_cnt = 1 (wrap).
